// File: rtl/melody_sequencer_pkg.sv
// Shared types and constants for the melody sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package melody_pkg;

    localparam int NOTE_W    = 4;
    localparam int MAX_NOTES = 8;
    localparam int IDX_W     = $clog2(MAX_NOTES);
    localparam int LEN_W     = 4;

    typedef logic [NOTE_W-1:0] note_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NOTE_ON = 2'd1,
        GAP     = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    localparam note_t NOTE_REST = 4'd0;

    // Lengths above the melody capacity play the whole melody.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_NOTES)) ? LEN_W'(MAX_NOTES) : len;
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Controller <-> sequencer bundle: playback request, melody data, key preempt, note outputs.
// Latency: n/a (wiring only).
// Backpressure: start/busy/done handshake; start is dropped unless the sequencer is idle.
interface melody_sequencer_if;
    import melody_pkg::*;

    logic                        start;
    logic                        abort;
    logic [NOTE_W*MAX_NOTES-1:0] melody_in;
    logic [LEN_W-1:0]            length_in;
    logic                        key_valid;
    note_t                       key_note;
    note_t                       piezo_out;
    note_t                       led_out;
    logic [IDX_W-1:0]            note_idx;
    logic                        busy;
    logic                        done;

    modport master (
        output start, abort, melody_in, length_in, key_valid, key_note,
        input  piezo_out, led_out, note_idx, busy, done
    );

    modport slave (
        input  start, abort, melody_in, length_in, key_valid, key_note,
        output piezo_out, led_out, note_idx, busy, done
    );

endinterface

// File: rtl/melody_sequencer_tick_prescaler.sv
// Free-running divider producing a 1-cycle tick every CLK_DIV cycles.
// Latency: first tick CLK_DIV cycles after clear.
// Backpressure: hold freezes the count and suppresses the tick.
module tick_prescaler #(
    parameter int CLK_DIV = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_tick = w_wrap && !i_hold;

    // Count cycles; wrap at CLK_DIV-1, restart on clear, freeze on hold.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Plays up to MAX_NOTES packed notes on piezo/LED with fixed note/gap timing; optional MELODY_SEQ_KEY_PREEMPT_EN key override.
// Latency: accepted start -> busy and note0 on the next cycle; done pulses one cycle after the last note.
// Backpressure: start is only taken in IDLE; abort returns to IDLE next cycle without a done pulse.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int CLK_DIV    = 5000000,
    parameter int NOTE_TICKS = 2,
    parameter int GAP_TICKS  = 1
) (
    input  logic                clk,
    input  logic                reset,
    melody_sequencer_if.slave   io_bus
);
    localparam int TCNT_W = 8;

    seq_state_t                  r_state;
    seq_state_t                  w_next_state;
    logic [NOTE_W*MAX_NOTES-1:0] r_melody;
    logic [LEN_W-1:0]            r_len;
    logic [IDX_W-1:0]            r_idx;
    logic [IDX_W-1:0]            w_next_idx;
    logic [TCNT_W-1:0]           r_ticks;
    logic                        w_accept;
    logic                        w_clear;
    logic                        w_hold;
    logic                        w_tick;
    note_t                       w_seq_note;

    assign w_accept = (r_state == IDLE) && io_bus.start && !io_bus.abort;
    // Every state entry restarts both the prescaler and the tick count, so slots are exact.
    assign w_clear  = (w_next_state != r_state);

`ifdef MELODY_SEQ_KEY_PREEMPT_EN
    logic  r_key_vld;
    note_t r_key_note;

    assign w_hold = io_bus.key_valid && ((r_state == NOTE_ON) || (r_state == GAP));

    // Register the held key so the override lines up with the sequencer's registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_vld  <= 1'b0;
            r_key_note <= NOTE_REST;
        end else begin
            r_key_vld  <= io_bus.key_valid;
            r_key_note <= io_bus.key_note;
        end
    end
`else
    assign w_hold = 1'b0;
`endif

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_hold  (w_hold),
        .o_tick  (w_tick)
    );

    // State, index and slot tick counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_ticks <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            if (w_clear) begin
                r_ticks <= '0;
            end else if (w_tick) begin
                r_ticks <= r_ticks + TCNT_W'(1);
            end
        end
    end

    // Melody and length are captured only when playback is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_melody <= '0;
            r_len    <= '0;
        end else if (w_accept) begin
            r_melody <= io_bus.melody_in;
            r_len    <= clamp_len(io_bus.length_in);
        end
    end

    // Next-state and next-index decode; abort overrides everything.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        if (io_bus.abort) begin
            w_next_state = IDLE;
            w_next_idx   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next_idx = '0;
                    if (io_bus.start) begin
                        w_next_state = (clamp_len(io_bus.length_in) != '0) ? NOTE_ON : DONE;
                    end
                end
                NOTE_ON: begin
                    if (w_tick && (r_ticks == TCNT_W'(NOTE_TICKS - 1))) begin
                        w_next_state = ({1'b0, r_idx} == (r_len - LEN_W'(1))) ? DONE : GAP;
                    end
                end
                GAP: begin
                    if (w_tick && (r_ticks == TCNT_W'(GAP_TICKS - 1))) begin
                        w_next_state = NOTE_ON;
                        w_next_idx   = r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    w_next_state = IDLE;
                    w_next_idx   = '0;
                end
                default: begin
                    w_next_state = IDLE;
                    w_next_idx   = '0;
                end
            endcase
        end
    end

    // Output decode from registered state; rests and gaps are silent.
    always_comb begin
        w_seq_note = NOTE_REST;
        if (r_state == NOTE_ON) begin
            w_seq_note = r_melody[r_idx*NOTE_W +: NOTE_W];
        end
    end

`ifdef MELODY_SEQ_KEY_PREEMPT_EN
    assign io_bus.piezo_out = r_key_vld ? r_key_note : w_seq_note;
`else
    assign io_bus.piezo_out = w_seq_note;
`endif
    assign io_bus.led_out  = io_bus.piezo_out;
    assign io_bus.note_idx = r_idx;
    assign io_bus.busy     = (r_state == NOTE_ON) || (r_state == GAP);
    assign io_bus.done     = (r_state == DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer against a slot-arithmetic reference model.
// Latency: one check set per cycle, sampled 1 time unit after the rising edge.
// Backpressure: exercises ignored starts, abort, mid-play reset and length clamping.
module tb_melody_sequencer;
    import melody_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int NOTE_TICKS = 2;
    localparam int GAP_TICKS  = 1;
    localparam int NOTE_CYC   = NOTE_TICKS * CLK_DIV;
    localparam int GAP_CYC    = GAP_TICKS * CLK_DIV;
    localparam int SLOT       = NOTE_CYC + GAP_CYC;
    localparam int HORIZON    = SLOT * MAX_NOTES + 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    melody_sequencer_if bus ();

    melody_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .NOTE_TICKS (NOTE_TICKS),
        .GAP_TICKS  (GAP_TICKS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs t cycles after the start edge. A melody of L notes is L slots of
    // (note + gap) minus the final gap, followed by a one-cycle done.
    function automatic void model(input int t, input logic [31:0] mel, input int L,
                                  input int done_t, input int stop,
                                  output logic [3:0] p, output logic [2:0] idx,
                                  output logic b, output logic d);
        int k;
        int r;
        p = 4'd0; idx = 3'd0; b = 1'b0; d = 1'b0;
        k = (t - 1) / SLOT;
        r = (t - 1) % SLOT;
        if (t >= stop) return;
        if (t == done_t) begin
            d   = 1'b1;
            idx = (L == 0) ? 3'd0 : 3'(L - 1);
        end else if (t < done_t) begin
            b   = 1'b1;
            idx = 3'(k);
            if (r < NOTE_CYC) p = mel[4*k +: 4];
        end
    endfunction

    task automatic check_outputs(input string name, input logic [3:0] ep, input logic [2:0] ei,
                                 input logic eb, input logic ed);
        check({name, ".piezo"}, 32'(bus.piezo_out), 32'(ep));
        check({name, ".led"},   32'(bus.led_out),   32'(ep));
        check({name, ".idx"},   32'(bus.note_idx),  32'(ei));
        check({name, ".busy"},  32'(bus.busy),      32'(eb));
        check({name, ".done"},  32'(bus.done),      32'(ed));
    endtask

    // One playback: start at cycle 0, optional abort / ignored start / reset at given cycles (-1 = none).
    task automatic play(input logic [31:0] mel, input int len, input int abort_at,
                        input int spur_at, input int rst_at, input bit abort_with_start,
                        input string name);
        int         L;
        int         done_t;
        int         stop;
        logic [3:0] ep;
        logic [2:0] ei;
        logic       eb;
        logic       ed;
        L      = ((len & 15) > MAX_NOTES) ? MAX_NOTES : (len & 15);
        done_t = (L == 0) ? 1 : SLOT * L - GAP_CYC + 1;
        stop   = abort_with_start ? 1 : HORIZON + 1;
        bus.melody_in = mel;
        bus.length_in = 4'(len);
        bus.start     = 1'b1;
        bus.abort     = abort_with_start;
        for (int t = 1; t <= HORIZON; t++) begin
            @(posedge clk);
            #1;
            bus.start     = 1'b0;
            bus.abort     = 1'b0;
            reset         = 1'b0;
            bus.melody_in = $urandom;
            bus.length_in = 4'($urandom);
            model(t, mel, L, done_t, stop, ep, ei, eb, ed);
            check_outputs(name, ep, ei, eb, ed);
            if (t == abort_at) begin
                bus.abort = 1'b1;
                if (stop > t + 1) stop = t + 1;
            end
            if (t == rst_at) begin
                reset = 1'b1;
                if (stop > t + 1) stop = t + 1;
            end
            if (t == spur_at && t <= done_t && t < stop) bus.start = 1'b1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.melody_in = '0;
        bus.length_in = '0;
        bus.key_valid = 1'b0;
        bus.key_note  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 4'd0, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_reset", 4'd0, 3'd0, 1'b0, 1'b0);

        play(32'h0000_0321, 3,  -1, -1, -1, 1'b0, "t1_basic");
        play($urandom,      0,  -1, -1, -1, 1'b0, "t2_len0");
        play($urandom,      12, -1, -1, -1, 1'b0, "t2_len12");
        play(32'h0000_0321, 3,  10, -1, -1, 1'b0, "t3_abort");
        play(32'h0000_0321, 3,  -1, -1, -1, 1'b0, "t3_restart");
        play(32'h0000_0321, 3,  -1,  5, -1, 1'b0, "t4_ignored_start");
        play(32'h0000_0321, 3,  -1, -1, 15, 1'b0, "t5_reset");
        play(32'h0000_0321, 3,  -1, -1, -1, 1'b0, "t5_after_reset");
        play(32'h0000_0321, 3,  -1, -1, -1, 1'b1, "abort_with_start");
        play(32'h1020_3040, 8,  -1, -1, -1, 1'b0, "rests");
        play(32'hFEDC_BA98, 1,  -1,  1, -1, 1'b0, "single_note");

        for (int i = 0; i < 30; i++) begin
            int a;
            int s;
            int r;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, HORIZON - 1)) : -1;
            s = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, HORIZON - 1)) : -1;
            r = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, HORIZON - 1)) : -1;
            play($urandom, int'($urandom_range(0, 15)), a, s, r, 1'b0, "random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
